// File: rtl/inst_fetch_pkg.sv
// Shared fetch-path defines, FSM state type and queue entry layout.
`ifndef INST_FETCH_DEFINES_SV
`define INST_FETCH_DEFINES_SV
`define InstAddrBus   31:0
`define InstBus       31:0
`define ZeroWord      32'h00000000
`define Stop          1'b1
`define NoStop        1'b0
`define RstEnable     1'b1
`define InstFetchIdle 2'b00
`define InstFetchWait 2'b01
`define InstFetchDrop 2'b10
`endif

package inst_fetch_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = `InstFetchIdle,
    IF_WAIT = `InstFetchWait,
    IF_DROP = `InstFetchDrop
  } if_state_e;

  typedef struct packed {
    logic [`InstAddrBus] pc;
    logic [`InstBus]     inst;
  } if_entry_t;

  localparam int unsigned ENTRY_W = $bits(if_entry_t);

  // Sequential word address; wraps 32'hFFFFFFFC -> 0 naturally.
  function automatic logic [31:0] next_word_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/inst_fifo.sv
// Prefetch queue: DEPTH-entry synchronous FIFO with clear, exposing the head word and fill count.
module inst_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [W-1:0]               data_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_i && !pop_i)      count_d = count_q + 1'b1;
      else if (!push_i && pop_i) count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; the top masks the head while the queue is empty.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch front end: req/ack fetch FSM feeding a prefetch queue whose head drives IF/ID.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h00000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush_i,
  input  logic [`InstAddrBus] new_pc_i,
  output logic                inst_req_o,
  output logic [`InstAddrBus] inst_addr_o,
  input  logic                inst_ack_i,
  input  logic [`InstBus]     inst_rdata_i,
  output logic [`InstAddrBus] if_pc,
  output logic [`InstBus]     if_inst,
  output logic                stallreq_from_if
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  if_state_e     state_q, state_d;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          push, pop, issue;
  if_entry_t     push_entry, head;
  logic          unused_stall;

  assign unused_stall = ^stall[5:2];

  assign push = (state_q == IF_WAIT) && inst_ack_i && !flush_i;
  assign pop  = (stall[1] == `NoStop) && (count != '0) && !flush_i;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (!push && pop) count_next = count - 1'b1;
  end

  // Credit check: with no request left in flight, only issue if the next fill leaves a free slot.
  assign issue = !flush_i && (stall[0] == `NoStop) && (count_next < CW'(DEPTH));

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    case (state_q)
      IF_IDLE: if (issue) state_d = IF_WAIT;
      IF_WAIT: begin
        if (inst_ack_i) begin
          fetch_pc_d = next_word_pc(fetch_pc_q);
          state_d    = issue ? IF_WAIT : IF_IDLE;
        end else if (flush_i) begin
          state_d = IF_DROP;
        end
      end
      IF_DROP: if (inst_ack_i) state_d = IF_IDLE;
      default: state_d = IF_IDLE;
    endcase
    if (flush_i) fetch_pc_d = {new_pc_i[31:2], 2'b00};
    // The bus address must not move while a request is still waiting for its ack.
    addr_d = (req_q && !inst_ack_i) ? addr_q : fetch_pc_d;
    req_d  = (state_d != IF_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == `RstEnable) begin
      state_q    <= IF_IDLE;
      fetch_pc_q <= RESET_PC;
      addr_q     <= RESET_PC;
      req_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
    end
  end

  assign push_entry.pc   = addr_q;
  assign push_entry.inst = inst_rdata_i;

  inst_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst     (rst),
    .clear_i (flush_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (push_entry),
    .head_o  (head),
    .count_o (count)
  );

  assign inst_req_o       = req_q;
  assign inst_addr_o      = addr_q;
  assign if_pc            = (count != '0) ? head.pc   : `ZeroWord;
  assign if_inst          = (count != '0) ? head.inst : `ZeroWord;
  assign stallreq_from_if = (count == '0) && !flush_i;

endmodule
